cpu_data_packer: RTL and testbench

CPU_DATA_PACKER -- requirements
Module: cpu_data_packer

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_data_packer_sync_fifo.sv | 62 ++++++
 rtl/cpu_data_packer.sv | 141 ++++++++++++++
 tb/tb_cpu_data_packer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU data packer: word type, header magic,
// packer FSM states and the header word builder.
package cpu_pkg;

  typedef logic [63:0] word_t;

  localparam logic [15:0] HDR_MAGIC = 16'hB47C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_TRL
  } state_e;

  function automatic word_t make_header(input logic [7:0] cpu_id,
                                        input logic [7:0] batch_len,
                                        input logic [31:0] seq);
    return {HDR_MAGIC, cpu_id, batch_len, seq};
  endfunction

endpackage

// File: rtl/cpu_data_packer_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// happens in the same cycle, so the slot being read is the one rewritten.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == LVL_FULL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LVL_ONE;
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - LVL_ONE;
      end
    end
  end

endmodule

// File: rtl/cpu_data_packer.sv
// Buffers CPU words and frames every BATCH_LEN of them as header, payload and
// XOR-checksum trailer toward a ready/valid sender stage.
module cpu_data_packer
  import cpu_pkg::*;
#(
  parameter int CPU_INDEX = 0,
  parameter int DEPTH     = 16,
  parameter int BATCH_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [63:0]              in_data,
  output logic                     out_vld,
  output logic [63:0]              out_data,
  output logic                     out_last,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]  CPU_ID    = 8'(CPU_INDEX);
  localparam logic [7:0]  BATCH_ID  = 8'(BATCH_LEN);
  localparam logic [7:0]  CNT_LAST  = 8'(BATCH_LEN - 1);
  localparam logic [AW:0] LVL_BATCH = (AW+1)'(BATCH_LEN);

  state_e       r_state;
  logic [31:0]  r_seq;
  word_t        r_csum;
  logic [7:0]   r_cnt;
  logic [31:0]  r_drop_cnt;

  word_t        w_head;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_level;
  logic         w_push;
  logic         w_pop;
  logic         w_drop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Words arriving during reset are discarded; the FIFO clears that same edge.
  assign w_push = in_vld && !rst;
  assign w_pop  = (r_state == ST_PAYLOAD) && out_rdy && !w_empty;
  assign w_drop = w_push && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_data),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_csum  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_level >= LVL_BATCH) begin
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (out_rdy) begin
            r_state <= ST_PAYLOAD;
            r_cnt   <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (out_rdy) begin
            r_csum <= r_csum ^ w_head;
            r_cnt  <= r_cnt + 8'd1;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_TRL;
            end
          end
        end
        ST_TRL: begin
          if (out_rdy) begin
            r_seq   <= r_seq + 32'd1;
            r_csum  <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  // Outputs decode only registered state; the head word cannot move while
  // stalled because only an accepted payload transfer pops the FIFO.
  always_comb begin
    out_vld  = 1'b0;
    out_last = 1'b0;
    out_data = '0;
    case (r_state)
      ST_HDR: begin
        out_vld  = 1'b1;
        out_data = make_header(CPU_ID, BATCH_ID, r_seq);
      end
      ST_PAYLOAD: begin
        out_vld  = 1'b1;
        out_data = w_head;
      end
      ST_TRL: begin
        out_vld  = 1'b1;
        out_last = 1'b1;
        out_data = r_csum;
      end
      default: ;
    endcase
  end

  assign fifo_level = w_level;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_cpu_data_packer.sv
// Self-checking bench for cpu_data_packer (CPU_INDEX=0, DEPTH=16, BATCH_LEN=4).
module tb_cpu_data_packer;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic [63:0] in_data;
  logic        out_vld;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_rdy;
  logic [4:0]  fifo_level;
  logic [31:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  cpu_data_packer #(
    .CPU_INDEX (0),
    .DEPTH     (16),
    .BATCH_LEN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_data    (in_data),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_rdy    (out_rdy),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hdr(input logic [31:0] seq);
    return {16'hB47C, 8'h00, 8'h04, seq};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b1; in_data = {$urandom, $urandom}; out_rdy = 1'b1;
    step();
    step();
    checks++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || out_data !== 64'd0 ||
        fifo_level !== 5'd0 || drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: vld=%b last=%b data=%h lvl=%0d drop=%0d, want all zero",
               out_vld, out_last, out_data, fifo_level, drop_cnt);
    end
    rst = 1'b0; in_vld = 1'b0;
  endtask

  task automatic test_basic();
    logic [63:0] acc;
    out_rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      acc = '0;
      for (int k = 1; k <= 4; k++) begin
        in_vld = 1'b1; in_data = 64'(b * 4 + k);
        step();
      end
      in_vld = 1'b0;
      checks++;
      if (out_vld !== 1'b0 || fifo_level !== 5'd4) begin
        failures++;
        $display("FAIL basic_pre_hdr: vld=%b lvl=%0d, want vld=0 lvl=4", out_vld, fifo_level);
      end
      step();
      checks++;
      if (out_vld !== 1'b1 || out_last !== 1'b0 || out_data !== hdr(32'(b))) begin
        failures++;
        $display("FAIL basic_hdr: vld=%b last=%b data=%h, want 1 0 %h",
                 out_vld, out_last, out_data, hdr(32'(b)));
      end
      for (int k = 1; k <= 4; k++) begin
        step();
        acc ^= 64'(b * 4 + k);
        checks++;
        if (out_vld !== 1'b1 || out_last !== 1'b0 || out_data !== 64'(b * 4 + k)) begin
          failures++;
          $display("FAIL basic_payload: vld=%b last=%b data=%h, want 1 0 %h",
                   out_vld, out_last, out_data, 64'(b * 4 + k));
        end
      end
      step();
      checks++;
      if (out_vld !== 1'b1 || out_last !== 1'b1 || out_data !== acc) begin
        failures++;
        $display("FAIL basic_trailer: vld=%b last=%b data=%h, want 1 1 %h",
                 out_vld, out_last, out_data, acc);
      end
      step();
      checks++;
      if (out_vld !== 1'b0 || out_last !== 1'b0) begin
        failures++;
        $display("FAIL basic_idle: vld=%b last=%b, want 0 0", out_vld, out_last);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w [4];
    logic [63:0] acc;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w[k] = {$urandom, $urandom};
      in_vld = 1'b1; in_data = w[k];
      step();
    end
    in_vld = 1'b0;
    step();
    checks++;
    if (out_vld !== 1'b1 || out_data !== hdr(32'd2)) begin
      failures++;
      $display("FAIL mid_hdr_seq2: vld=%b data=%h, want 1 %h", out_vld, out_data, hdr(32'd2));
    end
    step();
    step();
    step();
    checks++;
    if (out_data !== w[2]) begin
      failures++;
      $display("FAIL mid_third_word: data=%h, want %h", out_data, w[2]);
    end
    rst = 1'b1; in_vld = 1'b1; in_data = {$urandom, $urandom};
    step();
    rst = 1'b0; in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || out_data !== 64'd0 || fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: vld=%b last=%b data=%h lvl=%0d, want 0 0 0 0",
               out_vld, out_last, out_data, fifo_level);
    end
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      w[k] = {$urandom, $urandom};
      acc ^= w[k];
      in_vld = 1'b1; in_data = w[k];
      step();
    end
    in_vld = 1'b0;
    step();
    checks++;
    if (out_vld !== 1'b1 || out_data !== hdr(32'd0)) begin
      failures++;
      $display("FAIL mid_restart_hdr: vld=%b data=%h, want 1 %h", out_vld, out_data, hdr(32'd0));
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_data !== w[k]) begin
        failures++;
        $display("FAIL mid_restart_payload: data=%h, want %h", out_data, w[k]);
      end
    end
    step();
    checks++;
    if (out_last !== 1'b1 || out_data !== acc) begin
      failures++;
      $display("FAIL mid_restart_trailer: last=%b data=%h, want 1 %h", out_last, out_data, acc);
    end
    step();
  endtask

  task automatic test_overflow();
    logic [63:0] w [20];
    logic [63:0] extra;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      w[i] = {$urandom, $urandom};
      in_vld = 1'b1; in_data = w[i];
      step();
      if (i >= 4) begin
        checks++;
        if (out_vld !== 1'b1 || out_last !== 1'b0 || out_data !== hdr(32'd0)) begin
          failures++;
          $display("FAIL stall_stable: vld=%b last=%b data=%h, want 1 0 %h",
                   out_vld, out_last, out_data, hdr(32'd0));
        end
      end
    end
    in_vld = 1'b0;
    step();
    checks++;
    if (fifo_level !== 5'd16 || drop_cnt !== 32'd4 || out_data !== hdr(32'd0)) begin
      failures++;
      $display("FAIL overflow: lvl=%0d drop=%0d data=%h, want 16 4 %h",
               fifo_level, drop_cnt, out_data, hdr(32'd0));
    end
    out_rdy = 1'b1;
    step();
    checks++;
    if (out_data !== w[0]) begin
      failures++;
      $display("FAIL full_head: data=%h, want %h", out_data, w[0]);
    end
    extra = {$urandom, $urandom};
    in_vld = 1'b1; in_data = extra;
    step();
    in_vld = 1'b0;
    checks++;
    if (fifo_level !== 5'd16 || drop_cnt !== 32'd4 || out_data !== w[1]) begin
      failures++;
      $display("FAIL full_push_pop: lvl=%0d drop=%0d data=%h, want 16 4 %h",
               fifo_level, drop_cnt, out_data, w[1]);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_q [$];
    logic [63:0] acc, e, prev_data;
    logic [31:0] seq;
    logic        prev_stall, prev_last;
    int sent, got, pos;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    step();
    rst = 1'b0;
    sent = 0; got = 0; pos = 0; seq = '0; acc = '0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || got < 1000 || pos != 0); cyc++) begin
      if (prev_stall) begin
        checks++;
        if (out_vld !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          failures++;
          $display("FAIL rand_hold: vld=%b last=%b data=%h, want 1 %b %h",
                   out_vld, out_last, out_data, prev_last, prev_data);
        end
      end
      in_vld = (sent < 1000) && ($urandom_range(0, 3) == 0);
      if (in_vld) begin
        in_data = {$urandom, $urandom};
        exp_q.push_back(in_data);
        sent++;
      end
      out_rdy = ($urandom_range(0, 9) < 7);
      if (out_vld && out_rdy) begin
        checks++;
        if (pos == 0) begin
          if (out_data !== hdr(seq) || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rand_hdr: data=%h last=%b, want %h 0", out_data, out_last, hdr(seq));
          end
          acc = '0;
          pos = 1;
        end else if (pos <= 4) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
          if (out_data !== e || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rand_payload: data=%h last=%b, want %h 0", out_data, out_last, e);
          end
          acc ^= e;
          got++;
          pos++;
        end else begin
          if (out_data !== acc || out_last !== 1'b1) begin
            failures++;
            $display("FAIL rand_trailer: data=%h last=%b, want %h 1", out_data, out_last, acc);
          end
          seq++;
          pos = 0;
        end
      end
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
      prev_last  = out_last;
      step();
    end
    in_vld = 1'b0;
    checks++;
    if (got != 1000 || pos != 0 || exp_q.size() != 0 || drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rand_totals: got=%0d pos=%0d left=%0d drop=%0d, want 1000 0 0 0",
               got, pos, exp_q.size(), drop_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
